gcd_job_sequencer: RTL
======================

// Module: gcd_job_sequencer
// PURPOSE
//  Host-side initiator for the GCD machine's go/done handshake.
//  Buffers operand pairs in a job FIFO and issues them one at a time: drives op_a/op_b and a one-cycle go pulse.
//  Captures the result when the controller asserts done with output_en, then offers it on a valid/ready result port.
//  Sits between a host bus and the GCD controller/datapath pair. Handles zero operands and a hung engine.
// PARAMETERS
//  WIDTH    8    operand and result width
//  DEPTH    4    job FIFO entries (power of 2, >=2)
//  TIMEOUT  255  max cycles from go to output_en before abort (1..65535)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  job_valid  in   1      host offers job
//  job_ready  out  1      job FIFO not full
//  job_a      in   WIDTH  operand A
//  job_b      in   WIDTH  operand B
//  go         out  1      start pulse to GCD controller
//  op_a       out  WIDTH  operand A to datapath, held from ISSUE until result capture
//  op_b       out  WIDTH  operand B to datapath, held likewise
//  done       in   1      controller idle/finished flag (1 when idle)
//  output_en  in   1      controller result-valid strobe
//  gcd_in     in   WIDTH  datapath result, valid while output_en=1
//  res_valid  out  1      result available
//  res_ready  in   1      host accepts result
//  res_gcd    out  WIDTH  GCD result
//  res_err    out  1      1 = GCD(0,0) or timeout
//  busy       out  1      FSM not in IDLE, or FIFO not empty
// BEHAVIOUR
//  Reset (sync, active-high): FIFO flushed; FSM->IDLE; outputs go=0, op_a=op_b=0, res_valid=0, res_gcd=0, res_err=0, busy=0.
//   job_ready=1 from the first cycle after reset. Reset mid-job drops the in-flight job and all queued jobs.
//  FIFO: push on job_valid&&job_ready. job_ready=!full (not a function of pop).
//   Read/write pointers wrap modulo DEPTH. Entry count 0..DEPTH.
//  FSM states:
//   IDLE: if FIFO non-empty && done==1 -> pop head into op_a/op_b.
//    If either operand is 0 -> RESULT (bypass, no go).
//    Otherwise -> ISSUE.
//   ISSUE: go=1 for exactly one cycle; clear timeout counter -> WAIT.
//   WAIT: count cycles. If output_en==1: res_gcd<=gcd_in, res_err<=0 -> RESULT.
//    Else if count reaches TIMEOUT: res_gcd<=0, res_err<=1 -> RESULT.
//   RESULT: res_valid=1, res_gcd/res_err stable. On res_ready -> IDLE; next pop no earlier than the following cycle.
//  Bypass: gcd(x,0)=gcd(0,x)=x with err=0; gcd(0,0)=0 with err=1.
//  output_en is sampled only in WAIT; a pulse arriving in any other state is ignored.
//  Latency (nonzero operands, FIFO empty before push): push edge -> pop edge +1 -> go high in the next cycle.
//   res_valid rises the cycle after the output_en sample.
//  Push and pop in the same cycle: both occur and count is unchanged. A pop frees no space until the next cycle.
//  Timeout does not reset the engine; the next job waits in IDLE until done==1.
// TESTING
//  1. (12,18), behavioural controller model -> exactly one go pulse; op_a=12, op_b=18 held; res_gcd=6, res_err=0.
//  2. (0,9) then (7,0) -> no go issued; results 9 and 7, err=0, returned in order.
//  3. (0,0) -> res_gcd=0, res_err=1, no go.
//  4. DEPTH=4, res_ready=0, push 6 jobs back-to-back -> 5 accepted (1 in flight + 4 queued); job_ready=0 on the 6th.
//   Then release res_ready -> all 5 results returned in order.
//  5. TIMEOUT=20, model never asserts output_en -> res_err=1, res_gcd=0, res_valid rises 21 cycles after go.
//  6. rst asserted during WAIT with 3 jobs queued -> next cycle: go=0, res_valid=0, busy=0, job_ready=1, queue empty.

Source files
------------

// File: rtl/gcd_job_sequencer.sv
// Job FIFO plus go/done initiator for the GCD controller. Operand pairs are
// issued one at a time and results are returned on a valid/ready port.
module gcd_job_sequencer #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             job_valid_i,
    output logic             job_ready_o,
    input  logic [WIDTH-1:0] job_a_i,
    input  logic [WIDTH-1:0] job_b_i,
    output logic             go_o,
    output logic [WIDTH-1:0] op_a_o,
    output logic [WIDTH-1:0] op_b_o,
    input  logic             done_i,
    input  logic             output_en_i,
    input  logic [WIDTH-1:0] gcd_in_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_gcd_o,
    output logic             res_err_o,
    output logic             busy_o
);

    // state    | meaning
    // S_IDLE   | waiting for a queued job and an idle engine
    // S_ISSUE  | one-cycle go pulse, timer loaded
    // S_WAIT   | waiting for output_en or timer expiry
    // S_RESULT | result offered to host until res_ready
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam int          PW       = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [15:0] TMR_LOAD = 16'(TIMEOUT - 1);

    logic [WIDTH-1:0] fifo_a_q [DEPTH];
    logic [WIDTH-1:0] fifo_b_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] res_gcd_q, res_gcd_d;
    logic             res_err_q, res_err_d;
    logic [15:0]      tmr_q, tmr_d;

    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;

    assign job_ready_o = (count_q != CNT_FULL);
    assign push        = job_valid_i && job_ready_o;
    assign pop         = (state_q == S_IDLE) && (count_q != '0) && done_i;
    assign head_a      = fifo_a_q[rd_ptr_q];
    assign head_b      = fifo_b_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_a_q[wr_ptr_q] <= job_a_i;
            fifo_b_q[wr_ptr_q] <= job_b_i;
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        res_gcd_d = res_gcd_q;
        res_err_d = res_err_q;
        tmr_d     = tmr_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    op_a_d = head_a;
                    op_b_d = head_b;
                    // zero operands never reach the engine
                    if ((head_a == '0) || (head_b == '0)) begin
                        res_gcd_d = (head_a == '0) ? head_b : head_a;
                        res_err_d = (head_a == '0) && (head_b == '0);
                        state_d   = S_RESULT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                tmr_d   = TMR_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (output_en_i) begin
                    res_gcd_d = gcd_in_i;
                    res_err_d = 1'b0;
                    state_d   = S_RESULT;
                end else if (tmr_q == '0) begin
                    res_gcd_d = '0;
                    res_err_d = 1'b1;
                    state_d   = S_RESULT;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_RESULT: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            res_gcd_q <= '0;
            res_err_q <= 1'b0;
            tmr_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            res_gcd_q <= res_gcd_d;
            res_err_q <= res_err_d;
            tmr_q     <= tmr_d;
        end
    end

    assign go_o        = (state_q == S_ISSUE);
    assign op_a_o      = op_a_q;
    assign op_b_o      = op_b_q;
    assign res_valid_o = (state_q == S_RESULT);
    assign res_gcd_o   = res_gcd_q;
    assign res_err_o   = res_err_q;
    assign busy_o      = (state_q != S_IDLE) || (count_q != '0);

endmodule
